// File: rtl/hls_seq_pkg.sv
// Shared constants for the HLS job sequencer: FSM state codes, kernel
// ap_ctrl_hs register map and AXI response encoding.
package hls_seq_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_INIT_GIE = 3'd0;
  localparam seq_state_t ST_INIT_IER = 3'd1;
  localparam seq_state_t ST_IDLE     = 3'd2;
  localparam seq_state_t ST_ARG      = 3'd3;
  localparam seq_state_t ST_START    = 3'd4;
  localparam seq_state_t ST_WAIT     = 3'd5;
  localparam seq_state_t ST_CLR      = 3'd6;

  localparam logic [31:0] REG_CTRL = 32'h00;
  localparam logic [31:0] REG_GIE  = 32'h04;
  localparam logic [31:0] REG_IER  = 32'h08;
  localparam logic [31:0] REG_ISR  = 32'h0C;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic is_write_state(input seq_state_t s);
    return (s == ST_INIT_GIE) || (s == ST_INIT_IER) || (s == ST_ARG) ||
           (s == ST_START) || (s == ST_CLR);
  endfunction

endpackage

// File: rtl/hls_seq_fifo.sv
// Job descriptor queue: synchronous first-word-fall-through FIFO with
// wrap-around pointers carrying one extra bit to tell full from empty.
module hls_seq_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hls_job_sequencer.sv
// Job queue and ap_ctrl_hs sequencer acting as AXI-lite master on an HLS kernel.
// Define HLS_SEQ_POLL_EN to poll CTRL.ap_done instead of using the kernel interrupt.
module hls_job_sequencer
  import hls_seq_pkg::*;
#(
  parameter int          NUM_ARGS   = 4,
  parameter logic [31:0] ARG_BASE   = 32'h10,
  parameter logic [31:0] ARG_STRIDE = 32'h8,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [NUM_ARGS*32-1:0] job_args_i,
  output logic                  kctrl_axilite_awvalid,
  input  logic                  kctrl_axilite_awready,
  output logic [31:0]           kctrl_axilite_awaddr,
  output logic                  kctrl_axilite_wvalid,
  input  logic                  kctrl_axilite_wready,
  output logic [31:0]           kctrl_axilite_wdata,
  output logic [3:0]            kctrl_axilite_wstrb,
  input  logic                  kctrl_axilite_bvalid,
  output logic                  kctrl_axilite_bready,
  input  logic [1:0]            kctrl_axilite_bresp,
  output logic                  kctrl_axilite_arvalid,
  input  logic                  kctrl_axilite_arready,
  output logic [31:0]           kctrl_axilite_araddr,
  input  logic                  kctrl_axilite_rvalid,
  output logic                  kctrl_axilite_rready,
  input  logic [31:0]           kctrl_axilite_rdata,
  input  logic [1:0]            kctrl_axilite_rresp,
  input  logic                  kernel_irq_i,
  input  logic                  irq_en_i,
  input  logic                  irq_clr_i,
  output logic                  irq_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           jobs_done_o
);

  localparam int IW = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
`ifdef HLS_SEQ_POLL_EN
  localparam seq_state_t RESET_STATE = ST_IDLE;
`else
  localparam seq_state_t RESET_STATE = ST_INIT_GIE;
`endif

  seq_state_t                 state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [NUM_ARGS-1:0][31:0]  job_q, job_d;
  logic                       awvalid_q, wvalid_q, bready_q;
  logic [31:0]                awaddr_q, wdata_q;
  logic                       err_q, irq_q;
  logic [15:0]                done_cnt_q;

  logic                       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [NUM_ARGS*32-1:0]     fifo_rdata;
  logic                       b_hs, b_ok, r_hs, r_ok, done_evt, wr_launch;
  logic [31:0]                wr_addr, wr_data;
  logic                       unused_inputs;

  assign fifo_push = job_valid_i && job_ready_o;

  hls_seq_fifo #(.WIDTH(NUM_ARGS*32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (job_args_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign b_hs = kctrl_axilite_bvalid && bready_q;
  assign b_ok = (kctrl_axilite_bresp == AXI_RESP_OKAY);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    job_d    = job_q;
    fifo_pop = 1'b0;
    done_evt = 1'b0;
    case (state_q)
      ST_INIT_GIE: if (b_hs) state_d = ST_INIT_IER;
      ST_INIT_IER: if (b_hs) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_d    = fifo_rdata;
          idx_d    = '0;
          state_d  = ST_ARG;
        end
      end
      ST_ARG: begin
        if (b_hs) begin
          if (!b_ok)                            state_d = ST_IDLE;
          else if (idx_q == IW'(NUM_ARGS - 1))  state_d = ST_START;
          else                                  idx_d   = idx_q + 1'b1;
        end
      end
      ST_START: if (b_hs) state_d = b_ok ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
`ifdef HLS_SEQ_POLL_EN
        if (r_hs) begin
          if (!r_ok) begin
            state_d = ST_IDLE;
          end else if (kctrl_axilite_rdata[AP_DONE_BIT]) begin
            state_d  = ST_IDLE;
            done_evt = 1'b1;
          end
        end
`else
        if (kernel_irq_i) state_d = ST_CLR;
`endif
      end
      ST_CLR: begin
        if (b_hs) begin
          state_d  = ST_IDLE;
          done_evt = b_ok;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // A new write issues on entry to a write state or right after the previous B beat.
  assign wr_launch = is_write_state(state_d) && (!bready_q || b_hs);

  always_comb begin
    wr_addr = REG_CTRL;
    wr_data = 32'h0;
    case (state_d)
      ST_INIT_GIE: begin wr_addr = REG_GIE; wr_data = 32'h1; end
      ST_INIT_IER: begin wr_addr = REG_IER; wr_data = 32'h1; end
      ST_ARG: begin
        wr_addr = ARG_BASE + ARG_STRIDE * 32'(idx_d);
        wr_data = job_d[idx_d];
      end
      ST_START:    begin wr_addr = REG_CTRL; wr_data = 32'd1 << AP_START_BIT; end
      ST_CLR:      begin wr_addr = REG_ISR;  wr_data = 32'h1; end
      default:     begin wr_addr = REG_CTRL; wr_data = 32'h0; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RESET_STATE;
      idx_q      <= '0;
      job_q      <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      job_q   <= job_d;
      if (wr_launch) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        bready_q  <= 1'b1;
        awaddr_q  <= wr_addr;
        wdata_q   <= wr_data;
      end else begin
        if (kctrl_axilite_awready) awvalid_q <= 1'b0;
        if (kctrl_axilite_wready)  wvalid_q  <= 1'b0;
        if (b_hs)                  bready_q  <= 1'b0;
      end
      if ((b_hs && !b_ok) || (r_hs && !r_ok)) err_q <= 1'b1;
      // A completion wins over a clear pulse in the same cycle.
      if (done_evt && irq_en_i) irq_q <= 1'b1;
      else if (irq_clr_i)       irq_q <= 1'b0;
      if (done_evt) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

`ifdef HLS_SEQ_POLL_EN
  logic arvalid_q, rready_q, ar_launch;

  assign r_hs      = kctrl_axilite_rvalid && rready_q;
  assign r_ok      = (kctrl_axilite_rresp == AXI_RESP_OKAY);
  assign ar_launch = (state_d == ST_WAIT) && (!rready_q || r_hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else if (ar_launch) begin
      arvalid_q <= 1'b1;
      rready_q  <= 1'b1;
    end else begin
      if (kctrl_axilite_arready) arvalid_q <= 1'b0;
      if (r_hs)                  rready_q  <= 1'b0;
    end
  end

  assign kctrl_axilite_arvalid = arvalid_q;
  assign kctrl_axilite_rready  = rready_q;
`else
  assign r_hs                  = 1'b0;
  assign r_ok                  = 1'b1;
  assign kctrl_axilite_arvalid = 1'b0;
  assign kctrl_axilite_rready  = 1'b0;
`endif

  assign unused_inputs = ^{kctrl_axilite_arready, kctrl_axilite_rvalid, kctrl_axilite_rdata,
                           kctrl_axilite_rresp, kernel_irq_i};

  assign kctrl_axilite_araddr  = REG_CTRL;
  assign kctrl_axilite_awvalid = awvalid_q;
  assign kctrl_axilite_awaddr  = awaddr_q;
  assign kctrl_axilite_wvalid  = wvalid_q;
  assign kctrl_axilite_wdata   = wdata_q;
  assign kctrl_axilite_wstrb   = 4'hF;
  assign kctrl_axilite_bready  = bready_q;
  assign job_ready_o           = !fifo_full;
  assign busy_o                = (state_q != ST_IDLE) || !fifo_empty;
  assign irq_o                 = irq_q;
  assign err_o                 = err_q;
  assign jobs_done_o           = done_cnt_q;

endmodule

// File: tb/tb_hls_job_sequencer.sv
// Self-checking bench: randomized AXI-lite slave and kernel model, expected
// register-write stream built from the job descriptors pushed.
module tb_hls_job_sequencer;

  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            job_valid_i = 1'b0;
  logic            job_ready_o;
  logic [N*32-1:0] job_args_i = '0;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     awaddr, wdata, araddr, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic            kernel_irq, irq_en_i = 1'b1, irq_clr, irq_o, busy_o, err_o;
  logic [15:0]     jobs_done_o;

  always #5 clk_i = ~clk_i;

  hls_job_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_args_i(job_args_i),
    .kctrl_axilite_awvalid(awvalid), .kctrl_axilite_awready(awready), .kctrl_axilite_awaddr(awaddr),
    .kctrl_axilite_wvalid(wvalid), .kctrl_axilite_wready(wready), .kctrl_axilite_wdata(wdata),
    .kctrl_axilite_wstrb(wstrb),
    .kctrl_axilite_bvalid(bvalid), .kctrl_axilite_bready(bready), .kctrl_axilite_bresp(bresp),
    .kctrl_axilite_arvalid(arvalid), .kctrl_axilite_arready(arready), .kctrl_axilite_araddr(araddr),
    .kctrl_axilite_rvalid(rvalid), .kctrl_axilite_rready(rready), .kctrl_axilite_rdata(rdata),
    .kctrl_axilite_rresp(rresp),
    .kernel_irq_i(kernel_irq), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr),
    .irq_o(irq_o), .busy_o(busy_o), .err_o(err_o), .jobs_done_o(jobs_done_o)
  );

  int checks = 0;
  int failures = 0;

  // Controls written by the main sequence, read by the slave.
  int          max_dly = 0;
  bit          kern_hold = 1'b0;
  logic [31:0] inject_addr = 32'h0;
  int          inject_req = 0, clr_req = 0, race_req = 0;

  // Slave-owned observations.
  logic [63:0] wlog[$];
  int          stab_checks = 0, stab_bad = 0, strb_bad = 0, reads_since = 0;
  int          race_used = 0;

  logic [63:0] exp_q[$];
  int          exp_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI-lite slave, kernel and irq_clr driver, all stepping on the falling edge.
  initial begin : slave
    bit          got_aw, got_w, b_pend, cur_bad, kern_run, b_is_isr;
    logic [31:0] cap_a, cap_d, aw_a_prev, w_d_prev;
    logic        aw_v_prev, w_v_prev, b_rdy_prev, ar_v_prev, r_rdy_prev;
    int          aw_cnt, w_cnt, b_cnt, kern_cnt, inject_used, clr_used;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0;
    rdata = 0; rresp = 0; kernel_irq = 0; irq_clr = 0;
    got_aw = 0; got_w = 0; b_pend = 0; cur_bad = 0; kern_run = 0; b_is_isr = 0;
    aw_v_prev = 0; w_v_prev = 0; b_rdy_prev = 0; ar_v_prev = 0; r_rdy_prev = 0;
    aw_a_prev = 0; w_d_prev = 0; cap_a = 0; cap_d = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; kern_cnt = 0; inject_used = 0; clr_used = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) continue;
      if (aw_v_prev && !awready) begin
        stab_checks++;
        if (!(awvalid && awaddr == aw_a_prev)) stab_bad++;
      end
      if (w_v_prev && !wready) begin
        stab_checks++;
        if (!(wvalid && wdata == w_d_prev)) stab_bad++;
      end
      if (awready && aw_v_prev) begin
        got_aw = 1; cap_a = aw_a_prev; awready = 0; aw_cnt = $urandom_range(max_dly, 0);
      end else if (awvalid && !got_aw) begin
        if (aw_cnt == 0) awready = 1; else aw_cnt--;
      end
      if (wready && w_v_prev) begin
        got_w = 1; cap_d = w_d_prev; wready = 0; w_cnt = $urandom_range(max_dly, 0);
        if (wstrb !== 4'hF) strb_bad++;
      end else if (wvalid && !got_w) begin
        if (w_cnt == 0) wready = 1; else w_cnt--;
      end
      if (bvalid && b_rdy_prev) bvalid = 0;
      if (irq_clr) irq_clr = 0;
      if (got_aw && got_w) begin
        wlog.push_back({cap_a, cap_d});
        got_aw = 0; got_w = 0; b_pend = 1; b_cnt = $urandom_range(max_dly, 0);
        cur_bad = (inject_req > inject_used) && (cap_a == inject_addr);
        if (cur_bad) inject_used++;
        b_is_isr = (cap_a == 32'h0C);
        if (cap_a == 32'h0 && cap_d == 32'h1) begin
          kern_run = 1; kern_cnt = $urandom_range(5, 0); reads_since = 0;
        end
        if (b_is_isr) begin kernel_irq = 0; kern_run = 0; end
      end
      if (b_pend) begin
        if (b_cnt == 0) begin
          bvalid = 1; bresp = cur_bad ? 2'b10 : 2'b00; b_pend = 0;
          if (b_is_isr && race_req > race_used) begin irq_clr = 1; race_used++; end
        end else b_cnt--;
      end
      if (kern_run && !kern_hold) begin
        if (kern_cnt == 0) kernel_irq = 1; else kern_cnt--;
      end
      if (rvalid && r_rdy_prev) rvalid = 0;
      if (arready && ar_v_prev) begin
        arready = 0; rvalid = 1; rresp = 2'b00; reads_since++;
        rdata = (!kern_hold && reads_since >= 4) ? 32'h2 : 32'h0;
        if (rdata[1] && race_req > race_used) begin irq_clr = 1; race_used++; end
      end else if (arvalid && !arready) arready = 1;
      if (!irq_clr && clr_req > clr_used) begin irq_clr = 1; clr_used++; end
      aw_v_prev = awvalid; aw_a_prev = awaddr; w_v_prev = wvalid; w_d_prev = wdata;
      b_rdy_prev = bready; ar_v_prev = arvalid; r_rdy_prev = rready;
    end
  end

  // Expected writes for one job; abort_word >= 0 stops after that argument write.
  task automatic exp_job(input logic [N*32-1:0] a, input int abort_word);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({32'h10 + 32'h8 * i, a[32*i +: 32]});
      if (i == abort_word) return;
    end
    exp_q.push_back({32'h0, 32'h1});
`ifndef HLS_SEQ_POLL_EN
    exp_q.push_back({32'h0C, 32'h1});
`endif
  endtask

  task automatic push(input logic [N*32-1:0] a);
    int n = 0;
    job_args_i = a;
    job_valid_i = 1'b1;
    while (job_ready_o !== 1'b1 && n < 3000) begin @(negedge clk_i); n++; end
    check("push_ready", job_ready_o, 1'b1);
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (jobs_done_o !== 16'(exp_done) && n < 5000) begin @(negedge clk_i); n++; end
    check(tag, jobs_done_o, 16'(exp_done));
  endtask

  task automatic compare_log(input string tag);
    int bad = 0;
    check({tag, "_len"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      if (wlog[i] !== exp_q[i]) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  function automatic logic [N*32-1:0] rand_args();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : main
    logic [N*32-1:0] a;
    repeat (3) @(negedge clk_i);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_irq", irq_o, 0);
    check("rst_err", err_o, 0);
    check("rst_done", jobs_done_o, 0);
    rst_ni = 1'b1;
`ifndef HLS_SEQ_POLL_EN
    exp_q.push_back({32'h04, 32'h1});
    exp_q.push_back({32'h08, 32'h1});
`endif

    // Zero-wait single job with args 1..4.
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    push(a); exp_job(a, -1); exp_done++;
    wait_done("t1_done");
    check("t1_irq", irq_o, 1);
    check("t1_busy", busy_o, 0);
`ifdef HLS_SEQ_POLL_EN
    check("t1_reads", reads_since, 4);
`endif
    compare_log("t1");

    clr_req++;
    repeat (3) @(negedge clk_i);
    check("t2_irq_clr", irq_o, 0);

    // Queue fills while the kernel is held busy.
    kern_hold = 1'b1;
    a = rand_args(); push(a); exp_job(a, -1);
    repeat (40) @(negedge clk_i);
    for (int j = 0; j < 4; j++) begin a = rand_args(); push(a); exp_job(a, -1); end
    check("t3_full", job_ready_o, 0);
    check("t3_busy", busy_o, 1);
    a = rand_args();
    job_args_i = a; job_valid_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("t3_stall", job_ready_o, 0);
    check("t3_held_done", jobs_done_o, 16'(exp_done));
    kern_hold = 1'b0;
    push(a); exp_job(a, -1);
    exp_done += 6;
    wait_done("t3_done");
    compare_log("t3");

    // Random ready/response delays.
    max_dly = 5;
    for (int j = 0; j < 3; j++) begin a = rand_args(); push(a); exp_job(a, -1); end
    exp_done += 3;
    wait_done("t4_done");
    compare_log("t4");
    check("t4_err", err_o, 0);
    check("t4_stab_seen", stab_checks > 0, 1);
    check("t4_stab", stab_bad, 0);

    // SLVERR on argument word 2 aborts that job only.
    inject_addr = 32'h20; inject_req++;
    a = rand_args(); push(a); exp_job(a, 2);
    a = rand_args(); push(a); exp_job(a, -1);
    exp_done += 1;
    wait_done("t5_done");
    check("t5_err", err_o, 1);
    compare_log("t5");

    // Clear pulse coinciding with a completion, then a lone clear.
    max_dly = 0;
    clr_req++;
    repeat (3) @(negedge clk_i);
    check("t6_pre_clr", irq_o, 0);
    race_req++;
    a = rand_args(); push(a); exp_job(a, -1); exp_done++;
    wait_done("t6_done");
    check("t6_race_irq", irq_o, 1);
    clr_req++;
    repeat (3) @(negedge clk_i);
    check("t6_lone_clr", irq_o, 0);

    // Completion with interrupts disabled leaves irq_o low.
    irq_en_i = 1'b0;
    a = rand_args(); push(a); exp_job(a, -1); exp_done++;
    wait_done("t7_done");
    check("t7_irq_masked", irq_o, 0);
    compare_log("final");
    check("strobe", strb_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
